// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
// Optional packet lock is enabled by defining UART_TX_SCHED_LOCK_EN.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT} tx_sched_state_t;

  localparam int FRAME_WD_DEF = 8;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin picker: the first eligible requester at or after
// ptr_i wins, and the search wraps from N-1 back to 0.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  elig_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int c;
    c     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Explicit wrap so non-power-of-two N never indexes past N-1.
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      if (!any_o && elig_i[c]) begin
        any_o    = 1'b1;
        gnt_o[c] = 1'b1;
        idx_o    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter among NUM_REQ byte streams, one frame at a time.
// Define UART_TX_SCHED_LOCK_EN to keep the grant until a req_last byte is accepted.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int FRAME_WD = FRAME_WD_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*FRAME_WD-1:0]  req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         tx_frame_en,
  output logic [FRAME_WD-1:0]          tx_data_frame,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

  tx_sched_state_t     state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       gid_q, gid_d;
  logic [FRAME_WD-1:0] data_q, data_d;

  logic [NUM_REQ-1:0]  elig, gnt;
  logic [IW-1:0]       win;
  logic                win_any;
  logic                hold_ptr;
  logic [NUM_REQ-1:0]  cand;

`ifdef UART_TX_SCHED_LOCK_EN
  logic lock_q, lock_d;
  assign cand     = lock_q ? (req_valid & (NUM_REQ'(1) << gid_q)) : req_valid;
  assign hold_ptr = lock_q;
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign cand        = req_valid;
  assign hold_ptr    = 1'b0;
`endif

  assign elig = (state_q == IDLE) ? cand : '0;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .elig_i (elig),
    .ptr_i  (rr_ptr_q),
    .gnt_o  (gnt),
    .idx_o  (win),
    .any_o  (win_any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    data_d      = data_q;
    tx_frame_en = 1'b0;
`ifdef UART_TX_SCHED_LOCK_EN
    lock_d      = lock_q;
`endif
    case (state_q)
      IDLE: begin
        // elig is already gated by req_valid, so a winner means a handshake.
        if (win_any) begin
          data_d  = req_data[int'(win)*FRAME_WD +: FRAME_WD];
          gid_d   = win;
          state_d = LOAD;
`ifdef UART_TX_SCHED_LOCK_EN
          lock_d  = ~req_last[win];
`endif
        end
      end
      LOAD: begin
        tx_frame_en = 1'b1;
        state_d     = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
          if (!hold_ptr) rr_ptr_d = (gid_q == LAST_ID) ? '0 : gid_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      data_q   <= '0;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      data_q   <= data_d;
`ifdef UART_TX_SCHED_LOCK_EN
      lock_q   <= lock_d;
`endif
    end
  end

  assign req_ready     = gnt;
  assign tx_data_frame = data_q;
  assign grant_id      = gid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter between `NUM_REQ` byte-stream requesters (loopback FIFO drain, status reporter, debug console). Each requester offers bytes over a valid/ready handshake. The scheduler issues exactly one `tx_frame_en` pulse per accepted byte and holds off the next byte until the transmitter reports `tx_done`. It sits between the requester sources and the `tx` instance and replaces ad-hoc `frame_en` generation from FIFO flags.

## Interface
Reset is synchronous and active-high (`rst`); `clk` is the single clock.

Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `FRAME_WD`, default 8: data bits per frame, matching `tx`.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `req_valid`  in  NUM_REQ  requester i has a byte on its data slice
- `req_data`  in  NUM_REQ*FRAME_WD  packed bytes; requester i uses bits [i*FRAME_WD +: FRAME_WD]
- `req_last`  in  NUM_REQ  byte is the last of a packet (used only with lock feature)
- `req_ready`  out  NUM_REQ  one-hot accept strobe; a byte transfers when valid & ready
- `tx_frame_en`  out  1  one-cycle start pulse to transmitter
- `tx_data_frame`  out  FRAME_WD  registered byte to transmitter, stable from pulse until tx_done
- `tx_done`  in  1  one-cycle pulse from transmitter at end of stop bit
- `grant_id`  out  $clog2(NUM_REQ)  index of requester whose byte is in flight
- `busy`  out  1  high in LOAD and WAIT

## Operation
- FSM states: IDLE, LOAD, WAIT.
- IDLE:
  - Round-robin pick among eligible `req_valid` bits, starting at pointer `rr_ptr`.
  - Drive `req_ready[w]=1` combinationally for winner w only.
  - On handshake, latch the byte into `tx_data_frame` and w into `grant_id`, then go to LOAD.
  - No valid requester: stay in IDLE with `req_ready=0`.
- LOAD: `tx_frame_en=1` for exactly one cycle, then go to WAIT.
- WAIT:
  - `req_ready=0`.
  - On `tx_done`, set `rr_ptr <= (grant_id+1) mod NUM_REQ` and go to IDLE.
- `tx_done` outside WAIT is ignored.
- `req_ready` is never asserted outside IDLE, and never to more than one requester.
- Requesters may drop `req_valid` without a handshake; no byte is lost or duplicated.
- Pointer wrap: with NUM_REQ not a power of two, the pointer wraps from NUM_REQ-1 to 0 explicitly.
- Reset, including mid-frame:
  - State=IDLE, `rr_ptr=0`, `req_ready=0`, `tx_frame_en=0`, `tx_data_frame=0`, `grant_id=0`, `busy=0`, lock cleared.
  - A frame interrupted by reset is dropped; the transmitter shares `rst`.

## Timing
- Handshake in cycle t.
- `tx_frame_en` high in cycle t+1; `busy` high from t+1.
- `tx_done` sampled in cycle t+1+L, where L is the transmitter frame time.
- Back in IDLE at t+2+L; the next handshake can occur in cycle t+2+L.
- Overhead per byte: 2 cycles beyond the frame time.
- `tx_data_frame` and `grant_id` change only on handshake.

## Configuration
- Macro: `UART_TX_SCHED_LOCK_EN`.
- Defined (packet lock):
  - Accepting a byte with `req_last=0` sets the lock on `grant_id`.
  - While locked, only that requester is eligible in IDLE, and `rr_ptr` does not advance.
  - Accepting a byte with `req_last=1` clears the lock; the pointer then advances as normal.
  - Other requesters wait indefinitely while locked.
- Undefined: `req_last` is ignored and grant rotates after every byte.

## Structure
- Package `uart_pkg`:
  - `typedef enum logic [1:0] {IDLE, LOAD, WAIT} tx_sched_state_t`
  - Shared `FRAME_WD` default constant
- Sub-module `rr_arbiter` (combinational):
  - Inputs: eligible vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - Instantiated once; the FSM owns the pointer register.

## Test plan
Bench uses a transmitter model returning `tx_done` 20 cycles after `tx_frame_en`; NUM_REQ=4.
1. Reset held 3 cycles mid-WAIT → all outputs 0 next cycle, IDLE, no `tx_frame_en` until a new request.
2. Requesters 0..3 valid with bytes 8'hA0..8'hA3 continuously → transmit order A0,A1,A2,A3,A0; one pulse each, spaced 22 cycles.
3. Only requester 2 valid with 8'h5C; handshake at t → `tx_frame_en` at t+1, `grant_id=2`; next handshake no earlier than t+22.
4. Stray `tx_done` pulse in IDLE and a second one in LOAD → ignored: no state change, no pointer advance.
5. Requester 1 drops `req_valid` the cycle requester 0 wins; requester 3 valid → requester 3 is served next, and requester 1 is never acknowledged while invalid.
6. With `UART_TX_SCHED_LOCK_EN`: requester 1 sends 3 bytes (last on third) while requester 0 is valid → order R1,R1,R1,R0. Without the macro → order R1,R0,R1,R0 (req_last ignored).
